// File: rtl/music_pkg.sv
// Shared definitions for the music box song memory.
// Song word layout: [WORD_W-1:NOTE_LSB] note code, [NOTE_LSB-1:DUR_LSB] duration in ticks.
// Note codes: NOTE_REST = silence, 1..16 = key 0..15, NOTE_END = end-of-song marker.
// The playback reader decodes words with the same offsets.
package music_pkg;

  localparam int unsigned NOTE_W   = 5;
  localparam int unsigned DUR_W    = 7;
  localparam int unsigned WORD_W   = NOTE_W + DUR_W;
  localparam int unsigned DUR_LSB  = 0;
  localparam int unsigned NOTE_LSB = DUR_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 5'd31;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StNote,
    StRest,
    StFlush,
    StDone
  } wr_state_e;

endpackage

// File: rtl/sw_prio_enc.sv
// Lowest-set-bit priority encoder for the key switches.
// Ports:
//   sw_i  16-bit key vector, bit i = key i
//   nc_o  note code: 0 when no key is down, else (index of lowest set bit) + 1
module sw_prio_enc (
  input  logic [15:0] sw_i,
  output logic [4:0]  nc_o
);

  always_comb begin
    nc_o = 5'd0;
    // Scan downwards so the lowest set bit is the last one to assign.
    for (int i = 15; i >= 0; i--) begin
      if (sw_i[i]) begin
        nc_o = 5'(i + 1);
      end
    end
  end

endmodule

// File: rtl/note_writer.sv
// Recording engine for writing mode: times held keys and gaps against tick, packs each
// note/rest into a song word and writes the sequence, then an end marker, into regfile port C.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   writing      mode level; rising edge starts a recording, falling edge ends it
//   SW           key switches
//   tick         one-cycle time-base pulse
//   finish       one-cycle pulse ending the recording
//   addr_c, data_c, wen_c   song memory write port
//   length       words written so far, including the end marker
//   full         memory exhausted (sticky until the next recording starts)
//   recording    high while armed or recording notes/rests
module note_writer #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DUR_W = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        writing,
  input  logic [15:0]                 SW,
  input  logic                        tick,
  input  logic                        finish,
  output logic [15:0]                 addr_c,
  output logic [music_pkg::NOTE_W+DUR_W-1:0] data_c,
  output logic                        wen_c,
  output logic [15:0]                 length,
  output logic                        full,
  output logic                        recording
);

  import music_pkg::*;

  localparam int unsigned WordW = NOTE_W + DUR_W;
  localparam logic [DUR_W-1:0] DurMax  = '1;
  localparam logic [DUR_W-1:0] DurOne  = DUR_W'(1);
  localparam logic [15:0]      AddrLastNote = 16'(DEPTH - 2);
  localparam logic [15:0]      AddrEnd      = 16'(DEPTH - 1);

  wr_state_e          state_q, state_d;
  logic               writing_q;
  logic [15:0]        sw_q;
  logic [NOTE_W-1:0]  nc;
  logic [NOTE_W-1:0]  cur_q, cur_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [15:0]        addr_q, addr_d;
  logic [WordW-1:0]   data_q, data_d;
  logic               wen_q, wen_d;
  logic               full_q, full_d;
  logic               recording_q;

  logic               arm;
  logic               term;
  logic               emit;
  logic               emit_marker;
  logic [15:0]        wr_addr;
  logic               at_last;
  logic [DUR_W-1:0]   dur_word;
  logic [DUR_W-1:0]   dur_start;

  sw_prio_enc u_sw_prio_enc (
    .sw_i (sw_q),
    .nc_o (nc)
  );

  assign arm       = (state_q == StIdle) && writing && !writing_q;
  assign term      = finish || (writing_q && !writing);
  // addr_q lags a strobe by one cycle, so the slot the next write lands in is addr_q + wen_q.
  assign wr_addr   = addr_q + 16'(wen_q);
  assign at_last   = (wr_addr == AddrLastNote);
  assign dur_word  = (dur_q == '0) ? DurOne : dur_q;
  // A tick coinciding with the start of a segment belongs to that segment.
  assign dur_start = tick ? DurOne : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and segment bookkeeping
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    dur_d       = dur_q;
    emit        = 1'b0;
    emit_marker = 1'b0;
    unique case (state_q)
      StIdle: begin
        cur_d = NOTE_REST;
        dur_d = '0;
        if (arm) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (term) begin
          state_d = StFlush;
        end else if (nc != NOTE_REST) begin
          cur_d   = nc;
          dur_d   = dur_start;
          state_d = StNote;
        end
      end
      StNote, StRest: begin
        if (term) begin
          // A trailing rest is dropped; a pending note is written before the marker.
          emit    = (state_q == StNote);
          state_d = StFlush;
        end else if (nc != cur_q) begin
          emit  = 1'b1;
          cur_d = nc;
          dur_d = dur_start;
          if (at_last) begin
            state_d = StFlush;
          end else if (nc != NOTE_REST) begin
            state_d = StNote;
          end else begin
            state_d = StRest;
          end
        end else if (tick && (dur_q == DurMax)) begin
          // Duration field would overflow: close this word, continue the same note.
          emit  = 1'b1;
          dur_d = DurOne;
          if (at_last) begin
            state_d = StFlush;
          end
        end else if (tick) begin
          dur_d = dur_q + DurOne;
        end
      end
      StFlush: begin
        emit        = 1'b1;
        emit_marker = 1'b1;
        state_d     = writing ? StDone : StIdle;
      end
      StDone: begin
        if (!writing) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write port and status next values
  always_comb begin
    wen_d  = emit;
    data_d = data_q;
    if (emit_marker) begin
      data_d = {NOTE_END, {DUR_W{1'b0}}};
    end else if (emit) begin
      data_d = {cur_q, dur_word};
    end

    addr_d = addr_q;
    if (arm) begin
      addr_d = '0;
    end else if (wen_q) begin
      addr_d = addr_q + 16'd1;
    end

    full_d = full_q;
    if (arm) begin
      full_d = 1'b0;
    end else if (emit_marker && (wr_addr == AddrEnd)) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      writing_q   <= 1'b0;
      sw_q        <= '0;
      cur_q       <= NOTE_REST;
      dur_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wen_q       <= 1'b0;
      full_q      <= 1'b0;
      recording_q <= 1'b0;
    end else begin
      writing_q   <= writing;
      sw_q        <= SW;
      cur_q       <= cur_d;
      dur_q       <= dur_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wen_q       <= wen_d;
      full_q      <= full_d;
      recording_q <= (state_q == StArmed) || (state_q == StNote) || (state_q == StRest);
    end
  end

  assign addr_c    = addr_q;
  assign data_c    = data_q;
  assign wen_c     = wen_q;
  assign length    = addr_q;
  assign full      = full_q;
  assign recording = recording_q;

endmodule

// File: tb/tb_note_writer.sv
module tb_note_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        writing;
  logic [15:0] SW;
  logic        tick;
  logic        finish;

  logic [15:0] addr_c, length, addr8, length8;
  logic [11:0] data_c, data8;
  logic        wen_c, full, recording, wen8, full8, recording8;

  int checks = 0;
  int errors = 0;

  logic [27:0] log_q[$];
  logic [27:0] log8_q[$];

  always #5 clk = ~clk;

  note_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .writing   (writing),
    .SW        (SW),
    .tick      (tick),
    .finish    (finish),
    .addr_c    (addr_c),
    .data_c    (data_c),
    .wen_c     (wen_c),
    .length    (length),
    .full      (full),
    .recording (recording)
  );

  note_writer #(.DEPTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .writing   (writing),
    .SW        (SW),
    .tick      (tick),
    .finish    (finish),
    .addr_c    (addr8),
    .data_c    (data8),
    .wen_c     (wen8),
    .length    (length8),
    .full      (full8),
    .recording (recording8)
  );

  always @(negedge clk) begin
    if (wen_c) log_q.push_back({addr_c, data_c});
    if (wen8)  log8_q.push_back({addr8, data8});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wrd(input int a, input int n, input int d);
    logic [15:0] av;
    logic [4:0]  nv;
    logic [6:0]  dv;
    av = a[15:0];
    nv = n[4:0];
    dv = d[6:0];
    return {4'd0, av, nv, dv};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < log_q.size()) return {4'd0, log_q[i]};
    return 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] log8_at(input int i);
    if (i < log8_q.size()) return {4'd0, log8_q[i]};
    return 32'hffff_ffff;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(2);
    end
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    step(1);
    finish = 1'b0;
  endtask

  task automatic start_rec();
    log_q.delete();
    log8_q.delete();
    writing = 1'b1;
    step(3);
  endtask

  task automatic stop_rec();
    SW      = 16'h0000;
    writing = 1'b0;
    step(4);
  endtask

  initial begin
    rst_n = 1'b0; writing = 1'b0; SW = '0; tick = 1'b0; finish = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    check_eq("rst_addr", 32'(addr_c), 32'd0);
    check_eq("rst_data", 32'(data_c), 32'd0);
    check_eq("rst_wen", 32'(wen_c), 32'd0);
    check_eq("rst_length", 32'(length), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_recording", 32'(recording), 32'd0);

    // Basic sequence: key 3 x10, rest x4, key 0 x2, finish
    start_rec();
    check_eq("basic_armed_rec", 32'(recording), 32'd1);
    SW = 16'h0008;
    step(3);
    pulse_ticks(10);
    SW = 16'h0000;
    step(1);
    check_eq("lat_wen_early", 32'(wen_c), 32'd0);
    step(1);
    check_eq("lat_wen", 32'(wen_c), 32'd1);
    check_eq("lat_data", 32'(data_c), 32'h20a);
    check_eq("lat_addr", 32'(addr_c), 32'd0);
    step(1);
    check_eq("lat_wen_off", 32'(wen_c), 32'd0);
    check_eq("lat_addr_inc", 32'(addr_c), 32'd1);
    check_eq("lat_length_inc", 32'(length), 32'd1);
    pulse_ticks(4);
    SW = 16'h0001;
    step(4);
    pulse_ticks(2);
    pulse_finish();
    step(4);
    check_eq("basic_w0", log_at(0), wrd(0, 4, 10));
    check_eq("basic_w1", log_at(1), wrd(1, 0, 4));
    check_eq("basic_w2", log_at(2), wrd(2, 1, 2));
    check_eq("basic_w3", log_at(3), wrd(3, 31, 0));
    check_eq("basic_count", 32'(log_q.size()), 32'd4);
    check_eq("basic_length", 32'(length), 32'd4);
    check_eq("basic_done_rec", 32'(recording), 32'd0);
    check_eq("basic_full", 32'(full), 32'd0);
    stop_rec();

    // Saturation: key 15 held 300 ticks
    start_rec();
    SW = 16'h8000;
    step(3);
    pulse_ticks(300);
    SW = 16'h0000;
    step(4);
    pulse_finish();
    step(4);
    check_eq("sat_w0", log_at(0), wrd(0, 16, 127));
    check_eq("sat_w1", log_at(1), wrd(1, 16, 127));
    check_eq("sat_w2", log_at(2), wrd(2, 16, 46));
    check_eq("sat_w3", log_at(3), wrd(3, 31, 0));
    check_eq("sat_count", 32'(log_q.size()), 32'd4);
    stop_rec();

    // Priority and chord
    start_rec();
    SW = 16'h0030;
    step(3);
    pulse_ticks(5);
    SW = 16'h0020;
    step(4);
    pulse_ticks(3);
    pulse_finish();
    step(4);
    check_eq("prio_w0", log_at(0), wrd(0, 5, 5));
    check_eq("prio_w1", log_at(1), wrd(1, 6, 3));
    check_eq("prio_w2", log_at(2), wrd(2, 31, 0));
    check_eq("prio_count", 32'(log_q.size()), 32'd3);
    stop_rec();

    // Full with DEPTH=8: seven back-to-back notes, eighth press forces the flush
    start_rec();
    for (int k = 0; k < 7; k++) begin
      SW = 16'(1) << k;
      step(3);
      pulse_ticks(1);
    end
    SW = 16'h0080;
    step(4);
    check_eq("full_flag", 32'(full8), 32'd1);
    pulse_ticks(2);
    SW = 16'h0100;
    step(4);
    for (int k = 0; k < 7; k++) begin
      check_eq($sformatf("full_w%0d", k), log8_at(k), wrd(k, k + 1, 1));
    end
    check_eq("full_marker", log8_at(7), wrd(7, 31, 0));
    check_eq("full_count", 32'(log8_q.size()), 32'd8);
    check_eq("full_length", 32'(length8), 32'd8);
    check_eq("full_big_flag", 32'(full), 32'd0);
    stop_rec();

    // Leading/trailing silence, exit by writing falling
    start_rec();
    pulse_ticks(20);
    SW = 16'h0004;
    step(3);
    pulse_ticks(3);
    SW = 16'h0000;
    step(4);
    writing = 1'b0;
    step(4);
    check_eq("sil_w0", log_at(0), wrd(0, 3, 3));
    check_eq("sil_w1", log_at(1), wrd(1, 31, 0));
    check_eq("sil_count", 32'(log_q.size()), 32'd2);
    check_eq("sil_rec", 32'(recording), 32'd0);
    check_eq("sil_length", 32'(length), 32'd2);

    // Reset mid-note
    start_rec();
    SW = 16'h0002;
    step(3);
    pulse_ticks(2);
    SW = 16'h0001;
    step(4);
    pulse_ticks(2);
    check_eq("rstm_pre_addr", 32'(addr_c), 32'd1);
    check_eq("rstm_pre_rec", 32'(recording), 32'd1);
    log_q.delete();
    rst_n = 1'b0; writing = 1'b0; SW = '0;
    step(1);
    rst_n = 1'b1;
    check_eq("rstm_addr", 32'(addr_c), 32'd0);
    check_eq("rstm_length", 32'(length), 32'd0);
    check_eq("rstm_rec", 32'(recording), 32'd0);
    check_eq("rstm_wen", 32'(wen_c), 32'd0);
    step(5);
    check_eq("rstm_no_write", 32'(log_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
